// File: rtl/bcd_pkg.sv
// Shared constants, FSM state encoding and digit validation for the sequential BCD adder.
package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    function automatic logic is_bcd(input logic [DIGIT_W-1:0] digit);
        return (digit <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD add/subtract slice: nines'-complement of b_d in sub mode, +6 decimal correction.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a_d,
    input  logic [DIGIT_W-1:0] b_d,
    input  logic               cin,
    input  logic               sub,
    output logic [DIGIT_W-1:0] digit,
    output logic               cout
);

    logic [DIGIT_W-1:0] b_eff;
    logic [DIGIT_W:0]   t;
    logic [DIGIT_W:0]   t_adj;

    always_comb begin
        b_eff = sub ? (BCD_MAX - b_d) : b_d;
        t     = {1'b0, a_d} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, cin};
        // t never exceeds 19, so adding 6 and keeping the low nibble yields the decimal digit
        t_adj = t + 5'd6;
        cout  = (t > 5'd9);
        digit = cout ? t_adj[DIGIT_W-1:0] : t[DIGIT_W-1:0];
    end

endmodule

// File: rtl/bcd_seq_adder.sv
// Multi-digit BCD adder/subtractor, one digit per clock LSD first, with start/done handshake.
module bcd_seq_adder
    import bcd_pkg::*;
#(
    parameter int N_DIGITS = 4
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        start,
    input  logic                        sub,
    input  logic                        cin,
    input  logic [4*N_DIGITS-1:0]       a,
    input  logic [4*N_DIGITS-1:0]       b,
    output logic                        busy,
    output logic                        done,
    output logic [4*N_DIGITS-1:0]       sum,
    output logic                        cout,
    output logic                        err
);

    // Handshake: start is a level sampled only in IDLE; done is high for exactly the one
    // cycle spent in FIN, and sum/cout are final and stable from that cycle until the next
    // accepted start. start seen in RUN or FIN is dropped, never queued.

    localparam int W     = DIGIT_W * N_DIGITS;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       opa_q, opa_d;
    logic [W-1:0]       opb_q, opb_d;
    logic               sub_q, sub_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               err_q, err_d;

    logic               ops_ok;
    logic [DIGIT_W-1:0] dig_a, dig_b, dig_sum;
    logic               dig_cout;

    always_comb begin
        ops_ok = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!is_bcd(a[DIGIT_W*i +: DIGIT_W]) || !is_bcd(b[DIGIT_W*i +: DIGIT_W])) begin
                ops_ok = 1'b0;
            end
        end
    end

    assign dig_a = opa_q[DIGIT_W*idx_q +: DIGIT_W];
    assign dig_b = opb_q[DIGIT_W*idx_q +: DIGIT_W];

    bcd_digit_add u_digit (
        .a_d   (dig_a),
        .b_d   (dig_b),
        .cin   (carry_q),
        .sub   (sub_q),
        .digit (dig_sum),
        .cout  (dig_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    opa_d  = a;
                    opb_d  = b;
                    sub_d  = sub;
                    sum_d  = '0;
                    cout_d = 1'b0;
                    if (ops_ok) begin
                        err_d   = 1'b0;
                        idx_d   = '0;
                        // Subtraction is A + nines'(B) + 1, i.e. tens' complement
                        carry_d = sub ? 1'b1 : cin;
                        state_d = RUN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end
                end
            end
            RUN: begin
                sum_d[DIGIT_W*idx_q +: DIGIT_W] = dig_sum;
                carry_d = dig_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    cout_d  = dig_cout;
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == FIN);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_seq_adder.sv
// Directed bench for bcd_seq_adder (N_DIGITS=4): add, carry ripple, subtract, invalid digits,
// handshake robustness and mid-operation reset.
module tb_bcd_seq_adder;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        sub;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        err;

    int check_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    bcd_seq_adder #(.N_DIGITS(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .sub    (sub),
        .cin    (cin),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout),
        .err    (err)
    );

    // Issues one start pulse, scrambles the inputs after the sampling edge and waits
    // (bounded) for done. lat is the number of edges after the sampling edge before done
    // is seen (-1 on timeout); busy_cyc counts cycles with busy high.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                          input logic tc, output int lat, output int busy_cyc);
        @(negedge clk);
        a = ta; b = tb; sub = ts; cin = tc; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
        lat = -1;
        busy_cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
        check_cnt++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else pass_cnt++;
        check_cnt++; if (sum !== 16'h0000) $display("FAIL reset_sum got=%h exp=0000", sum); else pass_cnt++;
        check_cnt++; if (cout !== 1'b0) $display("FAIL reset_cout got=%b exp=0", cout); else pass_cnt++;
        check_cnt++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else pass_cnt++;
        resetn = 1'b1;
    endtask

    task automatic test_add();
        int lat, bc;
        run_op(16'h1234, 16'h5678, 1'b0, 1'b0, lat, bc);
        check_cnt++; if (lat !== 4) $display("FAIL add_latency got=%0d exp=4", lat); else pass_cnt++;
        check_cnt++; if (bc !== 4) $display("FAIL add_busy_cycles got=%0d exp=4", bc); else pass_cnt++;
        check_cnt++; if (sum !== 16'h6912) $display("FAIL add_sum got=%h exp=6912", sum); else pass_cnt++;
        check_cnt++; if (cout !== 1'b0) $display("FAIL add_cout got=%b exp=0", cout); else pass_cnt++;
        check_cnt++; if (err !== 1'b0) $display("FAIL add_err got=%b exp=0", err); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if (done !== 1'b0) $display("FAIL add_done_width got=%b exp=0", done); else pass_cnt++;
        check_cnt++; if (sum !== 16'h6912) $display("FAIL add_sum_hold got=%h exp=6912", sum); else pass_cnt++;
    endtask

    task automatic test_carry();
        int lat, bc;
        run_op(16'h9999, 16'h0001, 1'b0, 1'b0, lat, bc);
        check_cnt++; if (lat !== 4) $display("FAIL carry1_latency got=%0d exp=4", lat); else pass_cnt++;
        check_cnt++; if (sum !== 16'h0000) $display("FAIL carry1_sum got=%h exp=0000", sum); else pass_cnt++;
        check_cnt++; if (cout !== 1'b1) $display("FAIL carry1_cout got=%b exp=1", cout); else pass_cnt++;
        run_op(16'h9999, 16'h9999, 1'b0, 1'b1, lat, bc);
        check_cnt++; if (lat !== 4) $display("FAIL carry2_latency got=%0d exp=4", lat); else pass_cnt++;
        check_cnt++; if (sum !== 16'h9999) $display("FAIL carry2_sum got=%h exp=9999", sum); else pass_cnt++;
        check_cnt++; if (cout !== 1'b1) $display("FAIL carry2_cout got=%b exp=1", cout); else pass_cnt++;
    endtask

    task automatic test_sub();
        int lat, bc;
        for (int c = 0; c < 2; c++) begin
            run_op(16'h0100, 16'h0001, 1'b1, 1'(c), lat, bc);
            check_cnt++; if (lat !== 4) $display("FAIL sub_ge_latency cin=%0d got=%0d exp=4", c, lat); else pass_cnt++;
            check_cnt++; if (sum !== 16'h0099) $display("FAIL sub_ge_sum cin=%0d got=%h exp=0099", c, sum); else pass_cnt++;
            check_cnt++; if (cout !== 1'b1) $display("FAIL sub_ge_cout cin=%0d got=%b exp=1", c, cout); else pass_cnt++;
            run_op(16'h0001, 16'h0002, 1'b1, 1'(c), lat, bc);
            check_cnt++; if (sum !== 16'h9999) $display("FAIL sub_lt_sum cin=%0d got=%h exp=9999", c, sum); else pass_cnt++;
            check_cnt++; if (cout !== 1'b0) $display("FAIL sub_lt_cout cin=%0d got=%b exp=0", c, cout); else pass_cnt++;
        end
    endtask

    task automatic test_invalid();
        int lat, bc;
        run_op(16'h00A0, 16'h0000, 1'b0, 1'b0, lat, bc);
        check_cnt++; if (lat !== 0) $display("FAIL inv_latency got=%0d exp=0", lat); else pass_cnt++;
        check_cnt++; if (bc !== 0) $display("FAIL inv_busy_cycles got=%0d exp=0", bc); else pass_cnt++;
        check_cnt++; if (err !== 1'b1) $display("FAIL inv_err got=%b exp=1", err); else pass_cnt++;
        check_cnt++; if (sum !== 16'h0000) $display("FAIL inv_sum got=%h exp=0000", sum); else pass_cnt++;
        check_cnt++; if (cout !== 1'b0) $display("FAIL inv_cout got=%b exp=0", cout); else pass_cnt++;
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, lat, bc);
        check_cnt++; if (lat !== 4) $display("FAIL inv_next_latency got=%0d exp=4", lat); else pass_cnt++;
        check_cnt++; if (err !== 1'b0) $display("FAIL inv_next_err got=%b exp=0", err); else pass_cnt++;
        check_cnt++; if (sum !== 16'h0002) $display("FAIL inv_next_sum got=%h exp=0002", sum); else pass_cnt++;
    endtask

    task automatic test_start_held();
        int dones = 0;
        int lat = -1;
        logic [15:0] got_sum = '0;
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        // start stays high through RUN and FIN; raising it in IDLE would be a new request
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                if (lat < 0) begin
                    lat = i;
                    got_sum = sum;
                end
            end
            if (i < 5) begin
                a = 16'h0001 + 16'(i); b = 16'h0001;
            end else begin
                start = 1'b0;
            end
        end
        check_cnt++; if (dones !== 1) $display("FAIL held_done_count got=%0d exp=1", dones); else pass_cnt++;
        check_cnt++; if (lat !== 4) $display("FAIL held_latency got=%0d exp=4", lat); else pass_cnt++;
        check_cnt++; if (got_sum !== 16'h6912) $display("FAIL held_sum got=%h exp=6912", got_sum); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        int lat = -1;
        logic [15:0] got_sum = '0;
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                if (lat < 0) begin
                    lat = i;
                    got_sum = sum;
                end
            end
            if (i == 1) begin
                a = 16'h0001; b = 16'h0001; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        check_cnt++; if (dones !== 1) $display("FAIL b2b_done_count got=%0d exp=1", dones); else pass_cnt++;
        check_cnt++; if (lat !== 4) $display("FAIL b2b_latency got=%0d exp=4", lat); else pass_cnt++;
        check_cnt++; if (got_sum !== 16'h6912) $display("FAIL b2b_sum got=%h exp=6912", got_sum); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        int dones = 0;
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        check_cnt++; if (busy !== 1'b0) $display("FAIL rmid_busy got=%b exp=0", busy); else pass_cnt++;
        check_cnt++; if (done !== 1'b0) $display("FAIL rmid_done got=%b exp=0", done); else pass_cnt++;
        check_cnt++; if (sum !== 16'h0000) $display("FAIL rmid_sum got=%h exp=0000", sum); else pass_cnt++;
        check_cnt++; if (cout !== 1'b0) $display("FAIL rmid_cout got=%b exp=0", cout); else pass_cnt++;
        check_cnt++; if (err !== 1'b0) $display("FAIL rmid_err got=%b exp=0", err); else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check_cnt++; if (dones !== 0) $display("FAIL rmid_no_done got=%0d exp=0", dones); else pass_cnt++;
        run_op(16'h0001, 16'h0002, 1'b0, 1'b0, lat, bc);
        check_cnt++; if (lat !== 4) $display("FAIL rmid_next_latency got=%0d exp=4", lat); else pass_cnt++;
        check_cnt++; if (sum !== 16'h0003) $display("FAIL rmid_next_sum got=%h exp=0003", sum); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry();
        test_sub();
        test_invalid();
        test_start_held();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
